axi_burst_to_lite_bridge: RTL and testbench

//  Sits directly downstream of the cache-request arbiter's AXI4 master port and

---
 rtl/axi_burst_to_lite_bridge.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_axi_burst_to_lite_bridge.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_burst_to_lite_bridge.sv
// rtl/axi_burst_to_lite_bridge.sv - AXI4 burst to AXI4-Lite single-beat bridge
// Ports:
//   clk, rst            core clock, asynchronous active-high reset
//   s_axi_*             AXI4 slave side (AR/R/AW/W/B) facing the cache-request arbiter
//   m_axi_lite_*        AXI4-Lite master side (AR/R/AW/W/B) facing the peripheral fabric
//   busy                high whenever a burst is being processed
module axi_burst_to_lite_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ID_WIDTH-1:0]       s_axi_arid,
  input  logic [ADDR_WIDTH-1:0]     s_axi_araddr,
  input  logic [7:0]                s_axi_arlen,
  input  logic [2:0]                s_axi_arsize,
  input  logic [1:0]                s_axi_arburst,
  input  logic                      s_axi_arvalid,
  output logic                      s_axi_arready,
  output logic [ID_WIDTH-1:0]       s_axi_rid,
  output logic [DATA_WIDTH-1:0]     s_axi_rdata,
  output logic [1:0]                s_axi_rresp,
  output logic                      s_axi_rlast,
  output logic                      s_axi_rvalid,
  input  logic                      s_axi_rready,
  input  logic [ID_WIDTH-1:0]       s_axi_awid,
  input  logic [ADDR_WIDTH-1:0]     s_axi_awaddr,
  input  logic [7:0]                s_axi_awlen,
  input  logic [2:0]                s_axi_awsize,
  input  logic [1:0]                s_axi_awburst,
  input  logic                      s_axi_awvalid,
  output logic                      s_axi_awready,
  input  logic [DATA_WIDTH-1:0]     s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]   s_axi_wstrb,
  input  logic                      s_axi_wlast,
  input  logic                      s_axi_wvalid,
  output logic                      s_axi_wready,
  output logic [ID_WIDTH-1:0]       s_axi_bid,
  output logic [1:0]                s_axi_bresp,
  output logic                      s_axi_bvalid,
  input  logic                      s_axi_bready,
  output logic [ADDR_WIDTH-1:0]     m_axi_lite_araddr,
  output logic                      m_axi_lite_arvalid,
  input  logic                      m_axi_lite_arready,
  input  logic [DATA_WIDTH-1:0]     m_axi_lite_rdata,
  input  logic [1:0]                m_axi_lite_rresp,
  input  logic                      m_axi_lite_rvalid,
  output logic                      m_axi_lite_rready,
  output logic [ADDR_WIDTH-1:0]     m_axi_lite_awaddr,
  output logic                      m_axi_lite_awvalid,
  input  logic                      m_axi_lite_awready,
  output logic [DATA_WIDTH-1:0]     m_axi_lite_wdata,
  output logic [DATA_WIDTH/8-1:0]   m_axi_lite_wstrb,
  output logic                      m_axi_lite_wvalid,
  input  logic                      m_axi_lite_wready,
  input  logic [1:0]                m_axi_lite_bresp,
  input  logic                      m_axi_lite_bvalid,
  output logic                      m_axi_lite_bready,
  output logic                      busy
);

  typedef enum logic [2:0] {
    IDLE, RD_AR, RD_R, RD_BEAT, WR_W, WR_LITE, WR_B, WR_RESP
  } state_t;

  state_t                  state_q, state_d;
  logic                    acc_q, acc_d;
  logic [ID_WIDTH-1:0]     id_q, id_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [7:0]              len_q, len_d;
  logic [2:0]              size_q, size_d;
  logic [1:0]              burst_q, burst_d;
  logic [7:0]              beat_cnt_q, beat_cnt_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [1:0]              rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
  logic [1:0]              bresp_q, bresp_d;
  logic                    aw_done_q, aw_done_d;
  logic                    w_done_q, w_done_d;

  logic [ADDR_WIDTH-1:0]   step;
  logic [ADDR_WIDTH-1:0]   addr_next;
  logic                    is_last;
  logic                    aw_now;
  logic                    w_now;

  // The end of a write burst is decided by the beat counter alone.
  logic unused_wlast;
  assign unused_wlast = s_axi_wlast;

  // Beats wider than the 4-byte lite bus are clamped to 4-byte steps.
  always_comb begin
    step = ADDR_WIDTH'(1);
    if (size_q >= 3'd2)      step = ADDR_WIDTH'(4);
    else if (size_q == 3'd1) step = ADDR_WIDTH'(2);
    // FIXED holds the address; INCR and WRAP both advance (wrap boundary ignored).
    addr_next = (burst_q == 2'b00) ? addr_q : addr_q + step;
    is_last   = (beat_cnt_q == len_q);
  end

  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    addr_d     = addr_q;
    len_d      = len_q;
    size_d     = size_q;
    burst_d    = burst_q;
    beat_cnt_d = beat_cnt_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bresp_d    = bresp_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    aw_now     = 1'b0;
    w_now      = 1'b0;

    // AR has priority: AW is only offered when no read is requested.
    s_axi_arready      = acc_q;
    s_axi_awready      = acc_q & ~s_axi_arvalid;
    s_axi_rid          = '0;
    s_axi_rdata        = '0;
    s_axi_rresp        = 2'b00;
    s_axi_rlast        = 1'b0;
    s_axi_rvalid       = 1'b0;
    s_axi_wready       = 1'b0;
    s_axi_bid          = '0;
    s_axi_bresp        = 2'b00;
    s_axi_bvalid       = 1'b0;
    m_axi_lite_araddr  = '0;
    m_axi_lite_arvalid = 1'b0;
    m_axi_lite_rready  = 1'b0;
    m_axi_lite_awaddr  = '0;
    m_axi_lite_awvalid = 1'b0;
    m_axi_lite_wdata   = '0;
    m_axi_lite_wstrb   = '0;
    m_axi_lite_wvalid  = 1'b0;
    m_axi_lite_bready  = 1'b0;
    busy               = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (acc_q && s_axi_arvalid) begin
          id_d       = s_axi_arid;
          addr_d     = s_axi_araddr;
          len_d      = s_axi_arlen;
          size_d     = s_axi_arsize;
          burst_d    = s_axi_arburst;
          beat_cnt_d = 8'd0;
          bresp_d    = 2'b00;
          state_d    = RD_AR;
        end else if (acc_q && s_axi_awvalid) begin
          id_d       = s_axi_awid;
          addr_d     = s_axi_awaddr;
          len_d      = s_axi_awlen;
          size_d     = s_axi_awsize;
          burst_d    = s_axi_awburst;
          beat_cnt_d = 8'd0;
          bresp_d    = 2'b00;
          state_d    = WR_W;
        end
      end
      RD_AR: begin
        m_axi_lite_arvalid = 1'b1;
        m_axi_lite_araddr  = addr_q;
        if (m_axi_lite_arready) state_d = RD_R;
      end
      RD_R: begin
        m_axi_lite_rready = 1'b1;
        if (m_axi_lite_rvalid) begin
          rdata_d = m_axi_lite_rdata;
          rresp_d = m_axi_lite_rresp;
          state_d = RD_BEAT;
        end
      end
      RD_BEAT: begin
        s_axi_rvalid = 1'b1;
        s_axi_rid    = id_q;
        s_axi_rdata  = rdata_q;
        s_axi_rresp  = rresp_q;
        s_axi_rlast  = is_last;
        if (s_axi_rready) begin
          if (is_last) begin
            state_d = IDLE;
          end else begin
            beat_cnt_d = beat_cnt_q + 8'd1;
            addr_d     = addr_next;
            state_d    = RD_AR;
          end
        end
      end
      WR_W: begin
        s_axi_wready = 1'b1;
        if (s_axi_wvalid) begin
          wdata_d = s_axi_wdata;
          wstrb_d = s_axi_wstrb;
          state_d = WR_LITE;
        end
      end
      WR_LITE: begin
        // AW and W are independent channels; each valid drops once its own
        // handshake has been seen, and the beat moves on when both are done.
        m_axi_lite_awvalid = ~aw_done_q;
        m_axi_lite_awaddr  = addr_q;
        m_axi_lite_wvalid  = ~w_done_q;
        m_axi_lite_wdata   = wdata_q;
        m_axi_lite_wstrb   = wstrb_q;
        aw_now = aw_done_q | m_axi_lite_awready;
        w_now  = w_done_q | m_axi_lite_wready;
        if (aw_now && w_now) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = WR_B;
        end else begin
          aw_done_d = aw_now;
          w_done_d  = w_now;
        end
      end
      WR_B: begin
        m_axi_lite_bready = 1'b1;
        if (m_axi_lite_bvalid) begin
          // Response codes are ordered by severity, so the worst is the largest.
          if (m_axi_lite_bresp > bresp_q) bresp_d = m_axi_lite_bresp;
          if (is_last) begin
            state_d = WR_RESP;
          end else begin
            beat_cnt_d = beat_cnt_q + 8'd1;
            addr_d     = addr_next;
            state_d    = WR_W;
          end
        end
      end
      WR_RESP: begin
        s_axi_bvalid = 1'b1;
        s_axi_bid    = id_q;
        s_axi_bresp  = bresp_q;
        if (s_axi_bready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Registered acceptance: a new burst is only offered once back in IDLE.
    acc_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      acc_q      <= 1'b0;
      id_q       <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      size_q     <= '0;
      burst_q    <= '0;
      beat_cnt_q <= '0;
      rdata_q    <= '0;
      rresp_q    <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bresp_q    <= '0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      id_q       <= id_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      size_q     <= size_d;
      burst_q    <= burst_d;
      beat_cnt_q <= beat_cnt_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bresp_q    <= bresp_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
    end
  end

endmodule

// File: tb/tb_axi_burst_to_lite_bridge.sv
// tb/tb_axi_burst_to_lite_bridge.sv - scoreboard bench for axi_burst_to_lite_bridge
module tb_axi_burst_to_lite_bridge;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0]  s_arid, s_awid, s_rid, s_bid;
  logic [31:0] s_araddr, s_awaddr, s_rdata, s_wdata;
  logic [7:0]  s_arlen, s_awlen;
  logic [2:0]  s_arsize, s_awsize;
  logic [1:0]  s_arburst, s_awburst, s_rresp, s_bresp;
  logic        s_arvalid, s_arready, s_awvalid, s_awready;
  logic        s_rlast, s_rvalid, s_rready;
  logic [3:0]  s_wstrb;
  logic        s_wlast, s_wvalid, s_wready, s_bvalid, s_bready;
  logic [31:0] l_araddr, l_rdata, l_awaddr, l_wdata;
  logic        l_arvalid, l_arready, l_rvalid, l_rready;
  logic [1:0]  l_rresp, l_bresp;
  logic        l_awvalid, l_awready, l_wvalid, l_wready, l_bvalid, l_bready;
  logic [3:0]  l_wstrb;
  logic        busy;

  axi_burst_to_lite_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .s_axi_arid(s_arid), .s_axi_araddr(s_araddr), .s_axi_arlen(s_arlen),
    .s_axi_arsize(s_arsize), .s_axi_arburst(s_arburst), .s_axi_arvalid(s_arvalid),
    .s_axi_arready(s_arready),
    .s_axi_rid(s_rid), .s_axi_rdata(s_rdata), .s_axi_rresp(s_rresp), .s_axi_rlast(s_rlast),
    .s_axi_rvalid(s_rvalid), .s_axi_rready(s_rready),
    .s_axi_awid(s_awid), .s_axi_awaddr(s_awaddr), .s_axi_awlen(s_awlen),
    .s_axi_awsize(s_awsize), .s_axi_awburst(s_awburst), .s_axi_awvalid(s_awvalid),
    .s_axi_awready(s_awready),
    .s_axi_wdata(s_wdata), .s_axi_wstrb(s_wstrb), .s_axi_wlast(s_wlast),
    .s_axi_wvalid(s_wvalid), .s_axi_wready(s_wready),
    .s_axi_bid(s_bid), .s_axi_bresp(s_bresp), .s_axi_bvalid(s_bvalid), .s_axi_bready(s_bready),
    .m_axi_lite_araddr(l_araddr), .m_axi_lite_arvalid(l_arvalid), .m_axi_lite_arready(l_arready),
    .m_axi_lite_rdata(l_rdata), .m_axi_lite_rresp(l_rresp), .m_axi_lite_rvalid(l_rvalid),
    .m_axi_lite_rready(l_rready),
    .m_axi_lite_awaddr(l_awaddr), .m_axi_lite_awvalid(l_awvalid), .m_axi_lite_awready(l_awready),
    .m_axi_lite_wdata(l_wdata), .m_axi_lite_wstrb(l_wstrb), .m_axi_lite_wvalid(l_wvalid),
    .m_axi_lite_wready(l_wready),
    .m_axi_lite_bresp(l_bresp), .m_axi_lite_bvalid(l_bvalid), .m_axi_lite_bready(l_bready),
    .busy(busy)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  initial forever begin @(posedge clk); cyc++; end

  // Scoreboard queues, filled by the stimulus tasks from the reference model.
  logic [31:0] exp_lite_rd[$];
  logic [67:0] exp_lite_wr[$];
  logic [38:0] exp_r[$];
  logic [5:0]  exp_b[$];

  logic [31:0] rmem [logic [31:0]];
  logic [1:0]  rresp_tab [16];
  logic [1:0]  bresp_tab [16];
  logic [31:0] wd_buf [256];
  logic [3:0]  ws_buf [256];
  bit fast_slave = 1'b1;
  bit aw_lag = 1'b0;
  bit slow_r = 1'b0;
  bit fast_master = 1'b1;
  int hold_err = 0, dup_err = 0, early_b_err = 0, tie_err = 0;
  int rlast_cyc = 0, aw_cyc = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout/unexpected required=event", nm);
  endtask

  // Reference model: closed-form beat address from the burst parameters.
  function automatic logic [31:0] beat_addr(input logic [31:0] base, input logic [2:0] size,
                                            input logic [1:0] burst, input int i);
    int sh;
    sh = (size > 3'd2) ? 2 : int'(size);
    if (burst == 2'b00) return base;
    return base + 32'(i << sh);
  endfunction

  function automatic logic [31:0] lite_rdata(input logic [31:0] a);
    if (rmem.exists(a)) return rmem[a];
    return (a * 32'h9E3779B1) ^ 32'h13572468;
  endfunction

  // Lite peripheral model plus lite-side protocol monitors.
  logic        ar_hs, r_hs, aw_hs, w_hs, b_hs;
  logic [31:0] smp_araddr, smp_awaddr, smp_wdata, rd_addr, wr_addr, wr_data;
  logic [3:0]  smp_wstrb, wr_strb;
  logic [31:0] exp_a;
  logic [67:0] exp_w;
  int rd_state, rd_delay, w_age, b_delay;
  bit aw_got, w_got, b_pend;
  initial begin
    l_arready = 0; l_rvalid = 0; l_rdata = 0; l_rresp = 0;
    l_awready = 0; l_wready = 0; l_bvalid = 0; l_bresp = 0;
    rd_state = 0; rd_delay = 0; aw_got = 0; w_got = 0; b_pend = 0; w_age = 0; b_delay = 0;
    forever begin
      @(negedge clk);
      ar_hs = l_arvalid && l_arready;
      r_hs  = l_rvalid && l_rready;
      aw_hs = l_awvalid && l_awready;
      w_hs  = l_wvalid && l_wready;
      b_hs  = l_bvalid && l_bready;
      smp_araddr = l_araddr; smp_awaddr = l_awaddr; smp_wdata = l_wdata; smp_wstrb = l_wstrb;
      if ((aw_hs && aw_got) || (w_hs && w_got)) dup_err++;
      if ((w_got && l_wvalid) || (aw_got && l_awvalid)) hold_err++;
      if (l_bready && !(aw_got && w_got)) early_b_err++;
      if (ar_hs) begin
        if (exp_lite_rd.size() == 0) fail_now("lite_ar_unexpected");
        else begin
          exp_a = exp_lite_rd.pop_front();
          chk("lite_araddr", smp_araddr, exp_a);
        end
      end
      @(posedge clk); #1;
      if (rst) begin
        l_arready = 0; l_rvalid = 0; l_awready = 0; l_wready = 0; l_bvalid = 0;
        rd_state = 0; aw_got = 0; w_got = 0; b_pend = 0;
        continue;
      end
      if (r_hs) begin l_rvalid = 0; rd_state = 0; end
      if (ar_hs) begin
        rd_addr = smp_araddr; l_arready = 0; rd_state = 1;
        rd_delay = slow_r ? 20 : (fast_slave ? 0 : int'($urandom_range(0, 2)));
      end
      if (rd_state == 1) begin
        if (rd_delay == 0) begin
          l_rvalid = 1; l_rdata = lite_rdata(rd_addr); l_rresp = rresp_tab[rd_addr[5:2]];
          rd_state = 2;
        end else rd_delay--;
      end
      if (rd_state == 0) l_arready = fast_slave ? 1'b1 : 1'($urandom_range(0, 1));

      if (b_hs) begin l_bvalid = 0; aw_got = 0; w_got = 0; b_pend = 0; end
      if (aw_hs) begin aw_got = 1; wr_addr = smp_awaddr; end
      if (w_hs) begin w_got = 1; wr_data = smp_wdata; wr_strb = smp_wstrb; w_age = 0; end
      else if (w_got) w_age++;
      if (aw_got && w_got && !b_pend) begin
        if (exp_lite_wr.size() == 0) fail_now("lite_w_unexpected");
        else begin
          exp_w = exp_lite_wr.pop_front();
          chk("lite_write", {wr_addr, wr_data, wr_strb}, exp_w);
        end
        b_pend = 1;
        b_delay = fast_slave ? 0 : int'($urandom_range(0, 3));
      end
      if (b_pend && !l_bvalid) begin
        if (b_delay == 0) begin l_bvalid = 1; l_bresp = bresp_tab[wr_addr[5:2]]; end
        else b_delay--;
      end
      if (aw_lag) begin
        l_wready  = !w_got;
        l_awready = !aw_got && w_got && (w_age >= 3);
      end else begin
        l_wready  = !w_got && (fast_slave ? 1'b1 : 1'($urandom_range(0, 1)));
        l_awready = !aw_got && (fast_slave ? 1'b1 : 1'($urandom_range(0, 1)));
      end
    end
  end

  // Upstream ready generator.
  initial begin
    s_rready = 0; s_bready = 0;
    forever begin
      @(posedge clk); #1;
      s_rready = fast_master ? 1'b1 : ($urandom_range(0, 3) != 0);
      s_bready = fast_master ? 1'b1 : ($urandom_range(0, 3) != 0);
    end
  end

  // Upstream response monitor.
  logic [38:0] er;
  logic [5:0]  eb;
  initial forever begin
    @(negedge clk);
    if (s_rvalid && s_rready) begin
      if (exp_r.size() == 0) fail_now("r_unexpected");
      else begin
        er = exp_r.pop_front();
        chk("r_beat", {s_rid, s_rdata, s_rresp, s_rlast}, er);
        if (s_rlast) rlast_cyc = cyc + 1;
      end
    end
    if (s_bvalid && s_bready) begin
      if (exp_b.size() == 0) fail_now("b_unexpected");
      else begin
        eb = exp_b.pop_front();
        chk("b_resp", {s_bid, s_bresp}, eb);
      end
    end
    if ((!s_rvalid && s_rid != 0) || (!s_bvalid && s_bid != 0)) tie_err++;
  end

  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    logic [31:0] a;
    int n;
    for (int i = 0; i <= int'(len); i++) begin
      a = beat_addr(addr, size, burst, i);
      exp_lite_rd.push_back(a);
      exp_r.push_back({id, lite_rdata(a), rresp_tab[a[5:2]], (i == int'(len))});
    end
    @(posedge clk); #1;
    s_arid = id; s_araddr = addr; s_arlen = len; s_arsize = size; s_arburst = burst;
    s_arvalid = 1;
    n = 0;
    forever begin
      @(negedge clk);
      if (s_arready) break;
      n++;
      if (n > 5000) begin fail_now("ar_handshake"); break; end
    end
    @(posedge clk); #1;
    s_arvalid = 0;
  endtask

  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
    logic [31:0] a;
    logic [1:0]  worst;
    int n;
    worst = 2'b00;
    for (int i = 0; i <= int'(len); i++) begin
      a = beat_addr(addr, size, burst, i);
      exp_lite_wr.push_back({a, wd_buf[i], ws_buf[i]});
      if (bresp_tab[a[5:2]] > worst) worst = bresp_tab[a[5:2]];
    end
    exp_b.push_back({id, worst});
    @(posedge clk); #1;
    s_awid = id; s_awaddr = addr; s_awlen = len; s_awsize = size; s_awburst = burst;
    s_awvalid = 1;
    n = 0;
    forever begin
      @(negedge clk);
      if (s_awready) begin aw_cyc = cyc + 1; break; end
      n++;
      if (n > 5000) begin fail_now("aw_handshake"); break; end
    end
    @(posedge clk); #1;
    s_awvalid = 0;
    for (int i = 0; i <= int'(len); i++) begin
      if (!fast_master) repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
      s_wvalid = 1; s_wdata = wd_buf[i]; s_wstrb = ws_buf[i]; s_wlast = (i == int'(len));
      n = 0;
      forever begin
        @(negedge clk);
        if (s_wready) break;
        n++;
        if (n > 5000) begin fail_now("w_handshake"); break; end
      end
      @(posedge clk); #1;
      s_wvalid = 0; s_wlast = 0;
    end
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while ((exp_r.size() + exp_b.size() + exp_lite_rd.size() + exp_lite_wr.size()) != 0 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20000) fail_now({nm, "_drain"});
    @(posedge clk);
    @(negedge clk);
    chk({nm, "_busy"}, busy, 0);
  endtask

  task automatic check_quiet(input string nm);
    chk(nm, {l_arvalid, l_awvalid, l_wvalid, l_rready, l_bready,
             s_rvalid, s_bvalid, s_wready, busy}, 0);
  endtask

  task automatic fill_wbuf();
    for (int i = 0; i < 256; i++) begin
      wd_buf[i] = $urandom;
      ws_buf[i] = 4'($urandom_range(0, 15));
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog actual=no_finish required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    int v;
    logic [31:0] ra;
    logic [2:0]  rs;
    logic [1:0]  rb;
    logic [7:0]  rl;
    s_arid = 0; s_araddr = 0; s_arlen = 0; s_arsize = 0; s_arburst = 0; s_arvalid = 0;
    s_awid = 0; s_awaddr = 0; s_awlen = 0; s_awsize = 0; s_awburst = 0; s_awvalid = 0;
    s_wdata = 0; s_wstrb = 0; s_wlast = 0; s_wvalid = 0;
    for (int i = 0; i < 16; i++) begin
      v = int'($urandom_range(0, 2));
      rresp_tab[i] = (v == 0) ? 2'd0 : 2'(v + 1);
      v = int'($urandom_range(0, 2));
      bresp_tab[i] = (v == 0) ? 2'd0 : 2'(v + 1);
    end
    bresp_tab[0] = 2'd0;
    bresp_tab[1] = 2'd2;
    fill_wbuf();

    rst = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_quiet("reset_quiet");
    chk("reset_arready", s_arready, 0);
    chk("reset_sdata", {s_rdata, s_rresp, s_bresp}, 0);
    chk("reset_maddr", {l_araddr, l_awaddr, l_wdata}, 0);
    @(posedge clk); #2 rst = 0;
    @(negedge clk); chk("release_acc0", s_arready, 0);
    @(negedge clk); chk("release_acc1", s_arready, 1);

    // Read burst with known peripheral data.
    rmem[32'h1000] = 32'hA0; rmem[32'h1004] = 32'hA1;
    rmem[32'h1008] = 32'hA2; rmem[32'h100C] = 32'hA3;
    do_read(4'd5, 32'h1000, 8'd3, 3'd2, 2'b01);
    wait_done("t1");

    // Write burst, second lite beat answers SLVERR.
    wd_buf[0] = 32'hDEAD; wd_buf[1] = 32'hBEEF; ws_buf[0] = 4'hF; ws_buf[1] = 4'hF;
    do_write(4'd9, 32'h2000, 8'd1, 3'd2, 2'b01);
    wait_done("t2");

    // AR and AW requested together: read first, write right after.
    fill_wbuf();
    fork
      do_read(4'd3, 32'h4000, 8'd2, 3'd2, 2'b01);
      do_write(4'd6, 32'h5000, 8'd1, 3'd2, 2'b01);
      begin
        @(posedge clk); #1;
        @(negedge clk);
        chk("t3_arready", s_arready, 1);
        chk("t3_awready_blocked", s_awready, 0);
      end
    join
    wait_done("t3");
    chk("t3_aw_after_read", aw_cyc, rlast_cyc + 1);

    // Lite awready lags wready by three cycles.
    aw_lag = 1;
    fill_wbuf();
    do_write(4'd7, 32'h6000, 8'd2, 3'd2, 2'b01);
    wait_done("t4");
    aw_lag = 0;

    // FIXED burst and address wrap at the top of the address space.
    do_read(4'd2, 32'h3000, 8'd2, 3'd2, 2'b00);
    wait_done("t5_fixed");
    do_read(4'd1, 32'hFFFFFFFC, 8'd1, 3'd2, 2'b01);
    wait_done("t5_wrap");

    // Reset while waiting on lite R.
    slow_r = 1;
    do_read(4'd4, 32'h7000, 8'd3, 3'd2, 2'b01);
    v = 0;
    forever begin
      @(negedge clk);
      if (l_rready) break;
      v++;
      if (v > 100) begin fail_now("t6_reach_rd_r"); break; end
    end
    @(posedge clk); #2 rst = 1;
    @(negedge clk);
    check_quiet("t6_rst_quiet");
    exp_r.delete(); exp_b.delete(); exp_lite_rd.delete(); exp_lite_wr.delete();
    @(posedge clk); #2 rst = 0;
    slow_r = 0;
    @(negedge clk); chk("t6_acc0", s_arready, 0);
    @(negedge clk); chk("t6_acc1", s_arready, 1);
    do_read(4'd4, 32'h7000, 8'd3, 3'd2, 2'b01);
    wait_done("t6_fresh");

    // Randomized bursts with random back-pressure on both sides.
    for (int n = 0; n < 40; n++) begin
      fast_slave  = ($urandom_range(0, 3) == 0);
      fast_master = ($urandom_range(0, 3) == 0);
      ra = ($urandom_range(0, 4) == 0) ? (32'hFFFFFFF0 | 32'($urandom_range(0, 15))) : $urandom;
      rs = 3'($urandom_range(0, 3));
      rb = 2'($urandom_range(0, 2));
      rl = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(8, 20)) : 8'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 0) begin
        do_read(4'($urandom_range(1, 15)), ra, rl, rs, rb);
      end else begin
        fill_wbuf();
        do_write(4'($urandom_range(1, 15)), ra, rl, rs, rb);
      end
      wait_done("rand");
    end

    // Longest legal bursts.
    fast_slave = 1; fast_master = 1;
    do_read(4'hC, 32'h8000, 8'd255, 3'd2, 2'b01);
    wait_done("len255_rd");
    fill_wbuf();
    do_write(4'hD, 32'h9000, 8'd255, 3'd2, 2'b01);
    wait_done("len255_wr");

    chk("lite_hold_after_hs", hold_err, 0);
    chk("lite_duplicate_hs", dup_err, 0);
    chk("lite_bready_early", early_b_err, 0);
    chk("id_tie_zero", tie_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
